// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the LVDS receive deframer.
// Frame/lock state encodings, default sync dibits, word width helper.
package lvds_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_I    = 2'b01,
    S_Q    = 2'b11
  } frame_state_e;

  typedef enum logic {
    L_HUNT   = 1'b0,
    L_LOCKED = 1'b1
  } lock_state_e;

  localparam logic [1:0] I_SYNC_DEF = 2'b10;
  localparam logic [1:0] Q_SYNC_DEF = 2'b01;

  function automatic int word_w(input int half);
    return 4 * half;
  endfunction

endpackage

// File: rtl/lvds_rx_lock_ctrl.sv
// HUNT/LOCKED alignment tracker with good/bad frame hysteresis.
// In: clk, rst, enable, good/bad pulses. Out: locked, locked_nxt.
module lvds_rx_lock_ctrl
  import lvds_rx_pkg::*;
#(
  parameter int LOCK_FRAMES   = 4,
  parameter int UNLOCK_ERRORS = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_good,
  input  logic i_bad,
  output logic o_locked,
  output logic o_locked_nxt
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int BW = $clog2(UNLOCK_ERRORS + 1);
  localparam logic [GW-1:0] G_LAST = GW'(LOCK_FRAMES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(UNLOCK_ERRORS - 1);

  lock_state_e   state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= L_HUNT;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (!i_enable) begin
      state_d    = L_HUNT;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else begin
      case (state_q)
        L_HUNT: begin
          if (i_good) begin
            if (good_cnt_q == G_LAST) begin
              state_d    = L_LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GW'(1);
            end
          end else if (i_bad) begin
            good_cnt_d = '0;
          end
        end
        L_LOCKED: begin
          if (i_bad) begin
            if (bad_cnt_q == B_LAST) begin
              state_d   = L_HUNT;
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + BW'(1);
            end
          end else if (i_good) begin
            bad_cnt_d = '0;
          end
        end
        default: state_d = L_HUNT;
      endcase
    end
  end

  // locked_nxt lets the frame logic act on this frame's lock update
  always_comb begin
    o_locked     = (state_q == L_LOCKED);
    o_locked_nxt = (state_d == L_LOCKED);
  end

endmodule

// File: rtl/lvds_rx_deframer.sv
// Assembles I/Q dibit frames into FIFO words, tracks lock and stats.
// In: ddr clk/data, rst, enable, push mode, tag, clear, fifo full. Out: fifo strobe/data, lock, counters.
module lvds_rx_deframer
  import lvds_rx_pkg::*;
#(
  parameter int         HALF_DIBITS   = 8,
  parameter logic [1:0] I_SYNC        = I_SYNC_DEF,
  parameter logic [1:0] Q_SYNC        = Q_SYNC_DEF,
  parameter int         LOCK_FRAMES   = 4,
  parameter int         UNLOCK_ERRORS = 3,
  parameter int         CNT_W         = 16
) (
  input  logic                     i_ddr_clk,
  input  logic                     i_rst,
  input  logic [1:0]               i_ddr_data,
  input  logic                     i_enable,
  input  logic                     i_push_unlocked,
  input  logic                     i_sync_input,
  input  logic                     i_clear_stats,
  input  logic                     i_fifo_full,
  output logic                     o_fifo_write_clk,
  output logic                     o_fifo_push,
  output logic [4*HALF_DIBITS-1:0] o_fifo_data,
  output logic                     o_locked,
  output logic [CNT_W-1:0]         o_frame_err_cnt,
  output logic [CNT_W-1:0]         o_drop_cnt,
  output logic                     o_overflow,
  output logic [1:0]               o_debug_state
);

  localparam int W  = word_w(HALF_DIBITS);
  localparam int DW = $clog2(HALF_DIBITS);
  localparam logic [DW-1:0] I_LAST = DW'(HALF_DIBITS - 1);
  localparam logic [DW-1:0] Q_LAST = DW'(HALF_DIBITS - 2);

  frame_state_e     state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     sr_q, sr_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic tag_q, tag_d;
  logic good_q, good_d;
  logic bad_q, bad_d;
  logic push_q, push_d;
  logic ovf_q, ovf_d;
  logic full_q;
  logic locked, locked_nxt;
  logic elig;

  lvds_rx_lock_ctrl #(
    .LOCK_FRAMES  (LOCK_FRAMES),
    .UNLOCK_ERRORS(UNLOCK_ERRORS)
  ) u_lock (
    .i_clk       (i_ddr_clk),
    .i_rst       (i_rst),
    .i_enable    (i_enable),
    .i_good      (good_q),
    .i_bad       (bad_q),
    .o_locked    (locked),
    .o_locked_nxt(locked_nxt)
  );

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      tag_q   <= 1'b0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
      full_q  <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tag_q   <= tag_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      full_q  <= i_fifo_full;
      push_q  <= push_d;
      data_q  <= data_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!i_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_ddr_data == I_SYNC) begin
            state_d = S_I;
            cnt_d   = '0;
          end
        end
        S_I: begin
          if (cnt_q == I_LAST) begin
            cnt_d   = '0;
            state_d = (i_ddr_data == Q_SYNC) ? S_Q : S_IDLE;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        S_Q: begin
          if (cnt_q == Q_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The last Q dibit loads the finished word, so sr_q holds it for
  // exactly the cycle in which the push decision is registered.
  always_comb begin
    sr_d   = sr_q;
    tag_d  = tag_q;
    good_d = 1'b0;
    bad_d  = 1'b0;
    if (i_enable) begin
      case (state_q)
        S_IDLE: begin
          if (i_ddr_data == I_SYNC) begin
            sr_d  = {sr_q[W-3:0], i_ddr_data};
            tag_d = i_sync_input;
          end else if (good_q && locked_nxt) begin
            bad_d = 1'b1;
          end
        end
        S_I: begin
          sr_d = {sr_q[W-3:0], i_ddr_data};
          if (cnt_q == I_LAST && i_ddr_data != Q_SYNC) begin
            bad_d = 1'b1;
          end
        end
        S_Q: begin
          if (cnt_q == Q_LAST) begin
            sr_d   = {sr_q[W-3:0], i_ddr_data[1], tag_q};
            good_d = 1'b1;
          end else begin
            sr_d = {sr_q[W-3:0], i_ddr_data};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    elig   = i_enable && good_q && (locked_nxt || i_push_unlocked);
    push_d = elig && !full_q;
    data_d = push_d ? sr_q : data_q;
    err_d  = err_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (i_enable && bad_q && err_q != '1) begin
      err_d = err_q + CNT_W'(1);
    end
    if (elig && full_q) begin
      ovf_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end
    if (i_clear_stats) begin
      err_d  = '0;
      drop_d = '0;
      ovf_d  = 1'b0;
    end
  end

  assign o_fifo_write_clk = i_ddr_clk;
  assign o_fifo_push      = push_q;
  assign o_fifo_data      = data_q;
  assign o_locked         = locked;
  assign o_frame_err_cnt  = err_q;
  assign o_drop_cnt       = drop_q;
  assign o_overflow       = ovf_q;
  assign o_debug_state    = state_q;

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Directed bench for lvds_rx_deframer (HALF_DIBITS=8, LOCK=2, UNLOCK=3, CNT_W=2).
// Drives dibit frames, checks push/word/lock/stats with immediate assertions.
module tb_lvds_rx_deframer;

  logic        clk;
  logic        i_rst;
  logic [1:0]  i_ddr_data;
  logic        i_enable;
  logic        i_push_unlocked;
  logic        i_sync_input;
  logic        i_clear_stats;
  logic        i_fifo_full;
  logic        o_fifo_write_clk;
  logic        o_fifo_push;
  logic [31:0] o_fifo_data;
  logic        o_locked;
  logic [1:0]  o_frame_err_cnt;
  logic [1:0]  o_drop_cnt;
  logic        o_overflow;
  logic [1:0]  o_debug_state;

  lvds_rx_deframer #(
    .HALF_DIBITS  (8),
    .LOCK_FRAMES  (2),
    .UNLOCK_ERRORS(3),
    .CNT_W        (2)
  ) dut (
    .i_ddr_clk       (clk),
    .i_rst           (i_rst),
    .i_ddr_data      (i_ddr_data),
    .i_enable        (i_enable),
    .i_push_unlocked (i_push_unlocked),
    .i_sync_input    (i_sync_input),
    .i_clear_stats   (i_clear_stats),
    .i_fifo_full     (i_fifo_full),
    .o_fifo_write_clk(o_fifo_write_clk),
    .o_fifo_push     (o_fifo_push),
    .o_fifo_data     (o_fifo_data),
    .o_locked        (o_locked),
    .o_frame_err_cnt (o_frame_err_cnt),
    .o_drop_cnt      (o_drop_cnt),
    .o_overflow      (o_overflow),
    .o_debug_state   (o_debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int push_cnt = 0;
  int push_cyc = 0;
  int prev_push_cyc = 0;
  int pc0;

  logic        s_push, s_locked, s_ovf;
  logic [31:0] s_data;
  logic [1:0]  s_err, s_drop, m_state, m_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [13:0] ip,
                                           input logic [12:0] qp,
                                           input logic tg);
    return {2'b10, ip, 2'b01, qp, tg};
  endfunction

  task automatic step(input logic [1:0] d);
    i_ddr_data = d;
    @(posedge clk);
    #1;
    if (o_fifo_push === 1'b1) begin
      push_cnt++;
      prev_push_cyc = push_cyc;
      push_cyc = cyc;
    end
  endtask

  task automatic snap();
    s_push   = o_fifo_push;
    s_data   = o_fifo_data;
    s_locked = o_locked;
    s_err    = o_frame_err_cnt;
    s_drop   = o_drop_cnt;
    s_ovf    = o_overflow;
  endtask

  // Snapshot after dibit 0 shows the previous frame's results.
  task automatic frame(input logic [13:0] ip, input logic [12:0] qp,
                       input logic [1:0] qs, input logic tg,
                       input logic full_last, input logic clr_first);
    logic [1:0] d;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) d = 2'b10;
      else if (k < 8) d = ip[15-2*k -: 2];
      else if (k == 8) d = qs;
      else if (k < 15) d = qp[30-2*k -: 2];
      else d = {qp[0], 1'b1};
      i_sync_input  = (k == 0) ? tg : ~tg;
      i_fifo_full   = (k == 15) ? full_last : ~full_last;
      i_clear_stats = (k == 0) && clr_first;
      step(d);
      if (k == 0) snap();
      if (k == 8) m_state = o_debug_state;
      if (k == 9) m_err = o_frame_err_cnt;
    end
    i_sync_input  = 1'b0;
    i_fifo_full   = 1'b0;
    i_clear_stats = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_ddr_data = 2'b00; i_enable = 1'b1;
    i_push_unlocked = 1'b0; i_sync_input = 1'b0;
    i_clear_stats = 1'b0; i_fifo_full = 1'b0;

    // reset state
    step(2'b00); step(2'b00);
    chk("rst_push", o_fifo_push, 0);
    chk("rst_data", o_fifo_data, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_err", o_frame_err_cnt, 0);
    chk("rst_drop", o_drop_cnt, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_state", o_debug_state, 0);

    // reset mid-frame
    i_rst = 1'b0; i_push_unlocked = 1'b1;
    step(2'b10);
    for (int k = 0; k < 7; k++) step(2'b11);
    step(2'b01); step(2'b00);
    chk("mid_state", o_debug_state, 3);
    i_rst = 1'b1;
    step(2'b00); step(2'b00);
    chk("mrst_state", o_debug_state, 0);
    chk("mrst_push", o_fifo_push, 0);
    chk("mrst_data", o_fifo_data, 0);
    i_rst = 1'b0;
    for (int k = 0; k < 8; k++) step(2'b00);
    chk("mrst_nopush", push_cnt, 0);

    // unlocked push
    frame(14'h2C35, 13'h0F0F, 2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b00); snap();
    chk("unl_push", s_push, 1);
    chk("unl_locked", s_locked, 0);
    chk("unl_data", s_data, exp_word(14'h2C35, 13'h0F0F, 1'b0));
    chk("unl_cnt", push_cnt, 1);

    // acquisition
    i_enable = 1'b0; step(2'b00);
    i_enable = 1'b1; i_push_unlocked = 1'b0;
    frame(14'h3FFF, 13'h0, 2'b01, 1'b1, 1'b0, 1'b0);
    frame(14'h3FFF, 13'h0, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("acq1_push", s_push, 0);
    chk("acq1_locked", s_locked, 0);
    frame(14'h3FFF, 13'h0, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("acq2_push", s_push, 1);
    chk("acq2_locked", s_locked, 1);

    // hysteresis
    frame(14'h0, 13'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("acq3_push", s_push, 1);
    chk("acq3_data", s_data, 32'hBFFF_4001);
    chk("acq_spacing", push_cyc - prev_push_cyc, 16);
    chk("qmis_state", m_state, 0);
    chk("qmis_err", m_err, 1);
    frame(14'h0, 13'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("hy1_err", s_err, 1);
    frame(14'h0155, 13'h1AAA, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("good_state", m_state, 3);
    frame(14'h0, 13'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("hy_locked", s_locked, 1);
    chk("hy_err", s_err, 2);
    chk("hy_push", s_push, 1);
    chk("hy_data", s_data, exp_word(14'h0155, 13'h1AAA, 1'b0));
    frame(14'h0, 13'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("hy3_locked", s_locked, 1);
    frame(14'h0, 13'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("hy4_locked", s_locked, 1);
    chk("hy_sat_err", s_err, 3);
    i_clear_stats = 1'b1; step(2'b00); i_clear_stats = 1'b0;
    chk("unlock", o_locked, 0);
    chk("clr_err", o_frame_err_cnt, 0);

    // overflow
    frame(14'h0F0F, 13'h0333, 2'b01, 1'b0, 1'b0, 1'b0);
    frame(14'h2AAA, 13'h1555, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("ov1_push", s_push, 0);
    frame(14'h1111, 13'h0222, 2'b01, 1'b0, 1'b1, 1'b0);
    chk("ov2_push", s_push, 1);
    chk("ov2_locked", s_locked, 1);
    chk("ov2_data", s_data, exp_word(14'h2AAA, 13'h1555, 1'b1));
    frame(14'h1111, 13'h0222, 2'b01, 1'b0, 1'b1, 1'b0);
    chk("ov3_push", s_push, 0);
    chk("ov3_drop", s_drop, 1);
    frame(14'h1111, 13'h0222, 2'b01, 1'b0, 1'b1, 1'b0);
    chk("ov4_push", s_push, 0);
    chk("ov4_drop", s_drop, 2);
    chk("ov4_ovf", s_ovf, 1);
    chk("ov4_hold", s_data, exp_word(14'h2AAA, 13'h1555, 1'b1));
    frame(14'h0777, 13'h0444, 2'b01, 1'b1, 1'b0, 1'b1);
    chk("clr_drop", s_drop, 0);
    chk("clr_ovf", s_ovf, 0);
    chk("clr_push", s_push, 0);

    // saturation and disable
    for (int b = 0; b < 5; b++) begin
      frame(14'h0, 13'h0, 2'b11, 1'b0, 1'b0, 1'b0);
      if (b == 0) chk("o6_push", s_push, 1);
    end
    frame(14'h0003, 13'h0005, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("sat_err", s_err, 3);
    chk("sat_locked", s_locked, 0);
    frame(14'h0003, 13'h0005, 2'b01, 1'b0, 1'b1, 1'b0);
    chk("g1_locked", s_locked, 0);
    i_sync_input = 1'b1;
    step(2'b10); snap();
    i_sync_input = 1'b0;
    chk("g2_push", s_push, 0);
    chk("g2_locked", s_locked, 1);
    chk("g2_drop", s_drop, 1);
    for (int k = 0; k < 3; k++) step(2'b11);
    pc0 = push_cnt;
    i_enable = 1'b0;
    step(2'b11);
    chk("dis_state", o_debug_state, 0);
    chk("dis_locked", o_locked, 0);
    chk("dis_err", o_frame_err_cnt, 3);
    chk("dis_drop", o_drop_cnt, 1);
    chk("dis_ovf", o_overflow, 1);
    for (int k = 0; k < 10; k++) step(k[0] ? 2'b01 : 2'b10);
    chk("dis_idle", o_debug_state, 0);
    chk("dis_nopush", push_cnt - pc0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_rx_deframer.md
# lvds_rx_deframer

Parametrised successor to the modem LVDS receive deframer. It sits between the 2-bit DDR data lanes from the modem and the RX sample FIFO, and assembles I/Q frames into FIFO words. It adds three things the original does not have: a configurable frame size, a HUNT/LOCKED alignment tracker with hysteresis, and saturating frame-error and FIFO-drop counters. One instance is built per modem channel (sub-GHz and 2.4 GHz).

## Interface
Parameters:
- HALF_DIBITS, 8: dibits per I or Q half-frame, sync dibit included; minimum 3. Word width W = 4*HALF_DIBITS.
- I_SYNC, 2'b10: sync dibit that opens the I half.
- Q_SYNC, 2'b01: sync dibit that opens the Q half.
- LOCK_FRAMES, 4: consecutive good frames needed to move HUNT to LOCKED; minimum 1.
- UNLOCK_ERRORS, 3: consecutive bad frames needed to move LOCKED to HUNT; minimum 1.
- CNT_W, 16: width of the statistics counters.

Ports:
- i_ddr_clk, in, 1: the only clock; all logic on its rising edge.
- i_rst, in, 1: reset, synchronous, active-high.
- i_ddr_data, in, 2: deserialised dibit, one per clock.
- i_enable, in, 1: deframer enable.
- i_push_unlocked, in, 1: 1 = push frames while in HUNT; 0 = push only while LOCKED.
- i_sync_input, in, 1: external timestamp marker, tagged into each word.
- i_clear_stats, in, 1: clears both counters and o_overflow.
- i_fifo_full, in, 1: FIFO full flag.
- o_fifo_write_clk, out, 1: equal to i_ddr_clk.
- o_fifo_push, out, 1: one-cycle write strobe.
- o_fifo_data, out, W: assembled word.
- o_locked, out, 1: high while in LOCKED.
- o_frame_err_cnt, out, CNT_W: bad-frame count, saturating.
- o_drop_cnt, out, CNT_W: count of words lost to FIFO full, saturating.
- o_overflow, out, 1: sticky, set on any drop.
- o_debug_state, out, 2: frame FSM state.

## Operation
Frame FSM: S_IDLE=2'b00, S_I=2'b01, S_Q=2'b11.
- S_IDLE:
  - dibit == I_SYNC: go to S_I and latch i_sync_input as the frame tag.
  - otherwise: stay in S_IDLE.
  - if LOCKED and the dibit arrives on the cycle immediately after a frame end and is not I_SYNC: bad frame.
- S_I: shift HALF_DIBITS-1 payload dibits. The next dibit is then checked against Q_SYNC.
  - match: go to S_Q.
  - mismatch: bad frame; go to S_IDLE.
- S_Q: shift HALF_DIBITS-1 dibits; on the last dibit only bit [1] is kept.
  - Good frame; go to S_IDLE.
  - Push if (LOCKED or i_push_unlocked), evaluated after this frame's lock update.
- Word format, MSB first: {I_SYNC, I payload (2*HALF_DIBITS-2 bits), Q_SYNC, Q payload (2*HALF_DIBITS-3 bits), tag}.

Lock tracker:
- HUNT:
  - good frame increments the good counter; bad frame clears it.
  - good counter reaching LOCK_FRAMES: go to LOCKED and clear the counter.
- LOCKED:
  - bad frame increments the bad counter; good frame clears it.
  - bad counter reaching UNLOCK_ERRORS: go to HUNT.

Statistics:
- Bad frame: o_frame_err_cnt += 1.
- Push-eligible good frame while i_fifo_full=1: push suppressed, o_drop_cnt += 1, o_overflow set.
- Both counters saturate at 2^CNT_W-1.
- i_clear_stats has priority over a same-cycle increment or set; the result is 0.
- o_fifo_data holds its value between pushes.

i_enable=0:
- Frame FSM forced to S_IDLE; lock forced to HUNT; lock sub-counters cleared.
- No push, no counting. Statistics hold.

## Timing
- Reset values: state S_IDLE, HUNT, o_locked=0, o_fifo_push=0, o_fifo_data=0, counters=0, o_overflow=0.
- Reset mid-frame discards the partial frame; no push follows.
- A frame occupies exactly 2*HALF_DIBITS clocks.
- The final dibit is sampled at edge N. At edge N+1, all of the following are registered together:
  - o_fifo_push (high for exactly one cycle) and o_fifo_data;
  - o_locked;
  - counter updates.
- i_fifo_full is sampled at edge N only.
- Back-to-back frames give one push every 2*HALF_DIBITS cycles; there are no idle cycles.
- Q_SYNC mismatch at edge M: o_frame_err_cnt updates at M+1 and the FSM is in S_IDLE at M+1.

## Structure
- Package lvds_rx_pkg holds:
  - frame and lock state encodings;
  - default I_SYNC and Q_SYNC;
  - a function that computes W from HALF_DIBITS.
- Sub-module lvds_rx_lock_ctrl contains:
  - the HUNT/LOCKED FSM and both hysteresis counters;
  - inputs: good and bad pulses, enable, reset;
  - output: locked.
- The top level contains the frame FSM, shift register and statistics.

## Test plan
Defaults for all scenarios: HALF_DIBITS=8, LOCK_FRAMES=2, UNLOCK_ERRORS=3.
- Reset: assert i_rst for 2 cycles mid-frame → all outputs 0, no push afterwards until a full new frame arrives.
- Acquisition: 3 back-to-back good frames with I payload all ones, Q payload all zeros, i_sync_input=1, i_push_unlocked=0 →
  - no push for frame 1;
  - o_locked rises after frame 2, and frame 2 is pushed;
  - frame 3 pushed with o_fifo_data=32'h BFFF_4001;
  - pushes 16 cycles apart.
- Hysteresis: while LOCKED, 2 frames with a corrupt Q sync then 1 good frame → o_locked stays 1 and o_frame_err_cnt=2. Then 3 corrupt frames → o_locked falls after the third.
- Overflow: LOCKED with i_fifo_full=1 at the final dibit of 2 frames → no push, o_drop_cnt=2, o_overflow=1. Assert i_clear_stats in the same cycle as a third drop → o_drop_cnt=0.
- Unlocked push: i_push_unlocked=1 from reset, 1 good frame → push 1 cycle after its final dibit while o_locked=0.
- Saturation and disable: CNT_W=2 with 5 bad frames → o_frame_err_cnt=3. Drop i_enable mid-frame → FSM in S_IDLE, o_locked=0, counters held.
